// File: rtl/dice_roll_sequencer_pkg.sv
// ============================================================================
// Module   : dice_pkg
// Purpose  : Shared types, constants and RNG normalisation for the dice roll sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dice_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    REVEAL = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DIGIT_MAX  = 9;
  localparam int NUM_DIGITS = 4;

  // RNG nibbles 10..15 fold back onto 0..5 so the display never shows a non-digit.
  function automatic logic [3:0] norm_digit(input logic [3:0] v);
    return (v > 4'(DIGIT_MAX)) ? (v - 4'd10) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dice_roll_sequencer_spinner.sv
// ============================================================================
// Module   : digit_spinner
// Purpose  : One display digit: PER-cycle step counter, mod-10 digit register, lock flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module digit_spinner
  import dice_pkg::*;
#(
  parameter int PER   = 1,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       spin_en,
  input  logic       lock,
  input  logic [3:0] lock_val,
  output logic [3:0] digit,
  output logic       locked
);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(PER - 1);

  logic [CNT_W-1:0] step_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      digit    <= 4'd0;
      locked   <= 1'b0;
    end else if (clr) begin
      // Digit value is kept so the next spin continues from the shown face.
      step_cnt <= '0;
      locked   <= 1'b0;
    end else if (lock) begin
      digit    <= lock_val;
      locked   <= 1'b1;
      step_cnt <= '0;
    end else if (spin_en && !locked) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        digit    <= (digit == 4'(DIGIT_MAX)) ? 4'd0 : (digit + 4'd1);
      end else begin
        step_cnt <= step_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dice_roll_sequencer.sv
// ============================================================================
// Module   : dice_roll_sequencer
// Purpose  : Roll FSM: timed spin, then staggered per-digit lock to RNG values.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dice_roll_sequencer
  import dice_pkg::*;
#(
  parameter int SPIN_CYCLES    = 300_000_000,
  parameter int STAGGER_CYCLES = 50_000_000,
  parameter int PER0           = 30_000_000,
  parameter int PER1           = 18_000_000,
  parameter int PER2           = 42_000_000,
  parameter int PER3           = 24_000_000,
  parameter int CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       roll_req,
  input  logic [3:0] rng0,
  input  logic [3:0] rng1,
  input  logic [3:0] rng2,
  input  logic [3:0] rng3,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] locked,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] spin_tmr, spin_nxt;
  logic [CNT_W-1:0] stag_tmr, stag_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             clr, spin_en;
  logic [3:0]       lock_vec;
  logic [3:0]       rng_arr [NUM_DIGITS];
  logic [3:0]       digit_arr [NUM_DIGITS];

  assign rng_arr[0] = rng0;
  assign rng_arr[1] = rng1;
  assign rng_arr[2] = rng2;
  assign rng_arr[3] = rng3;

  assign digit0 = digit_arr[0];
  assign digit1 = digit_arr[1];
  assign digit2 = digit_arr[2];
  assign digit3 = digit_arr[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      spin_tmr <= '0;
      stag_tmr <= '0;
      idx      <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= next_state;
      spin_tmr <= spin_nxt;
      stag_tmr <= stag_nxt;
      idx      <= idx_nxt;
      busy     <= (next_state != IDLE);
      done     <= (next_state == DONE);
    end
  end

  always_comb begin
    next_state = state;
    spin_nxt   = spin_tmr;
    stag_nxt   = stag_tmr;
    idx_nxt    = idx;
    clr        = 1'b0;
    lock_vec   = 4'b0000;
    case (state)
      IDLE: begin
        if (roll_req) begin
          next_state = SPIN;
          spin_nxt   = SPIN_LAST;
          clr        = 1'b1;
        end
      end
      SPIN: begin
        if (spin_tmr == '0) begin
          next_state  = REVEAL;
          lock_vec[0] = 1'b1;
          stag_nxt    = STAG_LAST;
          idx_nxt     = 2'd1;
        end else begin
          spin_nxt = spin_tmr - CNT_W'(1);
        end
      end
      REVEAL: begin
        if (stag_tmr == '0) begin
          lock_vec[idx] = 1'b1;
          stag_nxt      = STAG_LAST;
          if (idx == 2'd3) next_state = DONE;
          else             idx_nxt    = idx + 2'd1;
        end else begin
          stag_nxt = stag_tmr - CNT_W'(1);
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign spin_en = (state == SPIN) || (state == REVEAL);

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int PER_K = (k == 0) ? PER0 : (k == 1) ? PER1 : (k == 2) ? PER2 : PER3;

    digit_spinner #(
      .PER   (PER_K),
      .CNT_W (CNT_W)
    ) u_spinner (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .spin_en  (spin_en),
      .lock     (lock_vec[k]),
      .lock_val (norm_digit(rng_arr[k])),
      .digit    (digit_arr[k]),
      .locked   (locked[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_dice_roll_sequencer.sv
// ============================================================================
// Module   : tb_dice_roll_sequencer
// Purpose  : Directed bench for dice_roll_sequencer (SPIN=20, STAGGER=5, PER=3,2,4,5).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dice_roll_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       roll_req;
  logic [3:0] rng0, rng1, rng2, rng3;
  logic [3:0] digit0, digit1, digit2, digit3, locked;
  logic       busy, done;
  // Second instance with PER0=1 exercises the 9 -> 0 wrap.
  logic [3:0] w_digit0, w_digit1, w_digit2, w_digit3, w_locked;
  logic       w_busy, w_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dice_roll_sequencer #(
    .SPIN_CYCLES(20), .STAGGER_CYCLES(5),
    .PER0(3), .PER1(2), .PER2(4), .PER3(5), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .roll_req(roll_req),
    .rng0(rng0), .rng1(rng1), .rng2(rng2), .rng3(rng3),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .locked(locked), .busy(busy), .done(done)
  );

  dice_roll_sequencer #(
    .SPIN_CYCLES(20), .STAGGER_CYCLES(5),
    .PER0(1), .PER1(2), .PER2(4), .PER3(5), .CNT_W(32)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .roll_req(roll_req),
    .rng0(rng0), .rng1(rng1), .rng2(rng2), .rng3(rng3),
    .digit0(w_digit0), .digit1(w_digit1), .digit2(w_digit2), .digit3(w_digit3),
    .locked(w_locked), .busy(w_busy), .done(w_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; leaves time 1 unit after the last edge.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse roll_req for one sampling edge; returns just after that edge (E0).
  task automatic roll();
    roll_req = 1'b1;
    adv(1);
    roll_req = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; roll_req = 1'b0;
    rng0 = 4'd0; rng1 = 4'd0; rng2 = 4'd0; rng3 = 4'd0;
    adv(3);
    chk("reset_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    chk("reset_locked", locked, 4'h0);
    chk("reset_busy_done", {busy, done}, 2'b00);
    rst_n = 1'b1;
    adv(2);

    // Roll 1: rng 7,3,9,1 from all-zero digits, with an ignored request at E0+10.
    rng0 = 4'd7; rng1 = 4'd3; rng2 = 4'd9; rng3 = 4'd1;
    roll();                                   // E0
    chk("r1_busy_e0", busy, 1'b1);
    adv(2);                                   // E0+2
    chk("r1_d0_e2", digit0, 4'd0);
    adv(1);                                   // E0+3
    chk("r1_d0_e3", digit0, 4'd1);
    adv(6);                                   // E0+9
    roll_req = 1'b1;
    adv(1);                                   // E0+10 (ignored)
    roll_req = 1'b0;
    adv(8);                                   // E0+18
    chk("r1_d0_e18", digit0, 4'd6);
    adv(1);                                   // E0+19
    chk("r1_d0_e19", digit0, 4'd6);
    chk("r1_locked_e19", locked, 4'b0000);
    adv(1);                                   // E0+20
    chk("r1_d0_lock", digit0, 4'd7);
    chk("r1_locked_e20", locked, 4'b0001);
    chk("r1_d3_e20", digit3, 4'd4);
    chk("r1_d2_e20", digit2, 4'd5);
    adv(4);                                   // E0+24
    chk("r1_d1_e24", digit1, 4'd2);
    adv(1);                                   // E0+25
    chk("r1_d1_lock", digit1, 4'd3);
    chk("r1_locked_e25", locked, 4'b0011);
    chk("r1_d3_e25", digit3, 4'd5);
    adv(1);                                   // E0+26
    chk("r1_d1_hold", digit1, 4'd3);
    adv(4);                                   // E0+30
    chk("r1_d2_lock", digit2, 4'd9);
    chk("r1_locked_e30", locked, 4'b0111);
    adv(4);                                   // E0+34
    chk("r1_d3_e34", digit3, 4'd6);
    chk("r1_done_e34", done, 1'b0);
    adv(1);                                   // E0+35
    chk("r1_digits_final", {digit3, digit2, digit1, digit0}, 16'h1937);
    chk("r1_locked_final", locked, 4'b1111);
    chk("r1_done_pulse", {busy, done}, 2'b11);
    chk("w_d0_final", w_digit0, 4'd7);
    roll_req = 1'b1;                          // coincides with done: ignored
    adv(1);                                   // E0+36
    roll_req = 1'b0;
    chk("r1_after_done", {busy, done}, 2'b00);
    chk("r1_locked_kept", locked, 4'b1111);

    // Roll 2: accepted two cycles after done; rng0=8 seeds the wrap check.
    rng0 = 4'd8; rng1 = 4'd2; rng2 = 4'd4; rng3 = 4'd6;
    roll();                                   // E0' = old E0+37
    chk("r2_busy", busy, 1'b1);
    chk("r2_locked_clr", locked, 4'b0000);
    chk("r2_digits_kept", {digit3, digit2, digit1, digit0}, 16'h1937);
    adv(35);                                  // E0'+35
    chk("r2_digits_final", {digit3, digit2, digit1, digit0}, 16'h6428);
    chk("r2_done", done, 1'b1);
    chk("w_r2_d0", w_digit0, 4'd8);
    adv(1);

    // Roll 3: wrap on the PER0=1 instance, then asynchronous abort at E0''+27.
    roll();
    adv(1);                                   // E0''+1
    chk("w_wrap_9", w_digit0, 4'd9);
    adv(1);                                   // E0''+2
    chk("w_wrap_0", w_digit0, 4'd0);
    chk("r3_d0_e2", digit0, 4'd8);
    adv(25);                                  // E0''+27
    chk("r3_locked_e27", locked, 4'b0011);
    rst_n = 1'b0;
    #1;
    chk("abort_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    chk("abort_locked", locked, 4'h0);
    chk("abort_busy_done", {busy, done}, 2'b00);
    adv(2);
    chk("abort_held", {busy, digit0}, 5'h00);
    rst_n = 1'b1;
    adv(1);

    // Roll 4: out-of-range RNG values normalise (12->2, 15->5, 10->0).
    rng0 = 4'd12; rng1 = 4'd15; rng2 = 4'd10; rng3 = 4'd4;
    roll();
    adv(20);
    chk("r4_d0_norm", digit0, 4'd2);
    adv(15);                                  // E0+35
    chk("r4_digits_norm", {digit3, digit2, digit1, digit0}, 16'h4052);
    chk("r4_done", done, 1'b1);
    adv(1);
    chk("r4_idle", {busy, done}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dice_roll_sequencer.md
# dice_roll_sequencer

Controls one dice roll for the four-digit display. A single-cycle roll request starts a timed spin. During the spin each digit counts 0–9 at its own rate. The digits then lock to the RNG values one at a time, digit0 first, with a fixed gap between locks. The block sits between the button edge detector / RNG and the seven-segment driver, and it owns the digit registers.

## Interface
- SPIN_CYCLES, 300_000_000: length of the spin phase, in clk cycles (≥1)
- STAGGER_CYCLES, 50_000_000: gap between successive digit locks (≥1)
- PER0, 30_000_000: digit0 step period in cycles (≥1)
- PER1, 18_000_000: digit1 step period (≥1)
- PER2, 42_000_000: digit2 step period (≥1)
- PER3, 24_000_000: digit3 step period (≥1)
- CNT_W, 32: width of every internal timer/counter; must hold the largest parameter
- clk  in  1  100 MHz system clock
- rst  in  1  reset, asynchronous, active-low
- roll_req  in  1  single-cycle roll pulse, already edge-detected
- rng0..rng3  in  4 each  RNG digits, sampled at lock time
- digit0..digit3  out  4 each  displayed digits, always 0–9
- locked  out  4  bit k=1 means digit k holds its final value
- busy  out  1  roll in progress
- done  out  1  one-cycle pulse when digit3 has locked

## Operation
- FSM states: IDLE, SPIN, REVEAL, DONE.
- IDLE + roll_req:
  - go to SPIN.
  - load the spin timer with SPIN_CYCLES-1.
  - clear all step counters and locked.
  - digit values are kept and spinning continues from them.
- roll_req is ignored in SPIN, REVEAL and DONE. There is no queuing.
- Spinning (SPIN and REVEAL, unlocked digits only):
  - step counter k increments each cycle.
  - when it equals PERk-1, digit k steps to (digit k + 1) mod 10, so 9 wraps to 0, and the counter clears.
  - locked digits hold their value.
- SPIN timer reaches 0:
  - go to REVEAL.
  - digit0 takes the RNG value and locked[0] is set.
  - load the stagger timer with STAGGER_CYCLES-1; lock index = 1.
- REVEAL, stagger timer reaches 0:
  - digit[idx] takes rng[idx] and locked[idx] is set.
  - if idx=3, go to DONE; otherwise idx+1 and reload the timer.
- DONE: lasts one cycle, done=1, then IDLE. locked stays 4'b1111 until the next roll.
- RNG normalisation: values 10–15 map to value-10 (12 shows as 2). The display never shows an out-of-range digit.
- busy=1 in SPIN, REVEAL and DONE.

## Timing
- Reset, asynchronous:
  - state IDLE, digits 0, locked 0, busy 0, done 0, all timers 0.
  - a reset in mid-roll aborts immediately; no partial state survives.
- Take E0 as the edge that samples roll_req in IDLE:
  - busy is high from E0.
  - first step of digit k lands at edge E0+PERk.
  - digit0 locks at E0+SPIN_CYCLES.
  - digit k locks at E0+SPIN_CYCLES+k·STAGGER_CYCLES.
  - done is high for exactly the cycle after the digit3 lock edge.
  - busy falls one edge later.
- A step and a lock on the same edge for the same digit: the lock wins.
- A roll_req coinciding with done is ignored. The first accepted roll is the cycle after busy falls.
- All outputs are registered. There is no combinational path from roll_req or rng to the outputs.

## Structure
- Package dice_pkg:
  - state enum (IDLE, SPIN, REVEAL, DONE).
  - DIGIT_MAX=9.
  - NUM_DIGITS=4.
  - the RNG normalisation function.
- Sub-module digit_spinner, instantiated four times with PER as a parameter:
  - step counter plus mod-10 digit register.
  - inputs: spin_en, lock, lock_val, clr.
- The top-level FSM holds the spin/stagger timers and the lock index.

## Test plan
Bench parameters: SPIN=20, STAGGER=5, PER0..3=3,2,4,5.
- Reset: rst=0 mid-stream → digit0..3=0, locked=0, busy=0, done=0 without waiting for a clk edge.
- Full roll, rng=7,3,9,1:
  - busy high at E0.
  - digit0=7 at E0+20, digit1=3 at E0+25, digit2=9 at E0+30, digit3=1 at E0+35.
  - done high for one cycle only, right after E0+35.
  - locked=4'b1111 afterwards.
- Spin rate, from digits=0:
  - digit0 steps at E0+3,6,…,18 and shows 6 just before it locks.
  - digit3 shows 4 at E0+20 and keeps spinning until it locks.
- Wrap: PER0=1 with digit0=8 at start → 9 at E0+1, 0 at E0+2.
- Ignore/restart:
  - roll_req at E0+10 and on the done cycle → no effect on lock times.
  - roll_req two cycles after done → new roll, locked clears to 0.
- Abort and normalisation:
  - rst asserted at E0+27 → IDLE, digits 0.
  - new roll with rng0=12 → digit0=2.
